basic_sync_fifo: RTL and testbench
==================================

# basic_sync_fifo

Synchronous single-clock first-word-fall-through FIFO used as the generic flit buffer of the NoC link controller (send, receive and NI-side buffers). Entries are written with an enqueue strobe and the head entry is presented continuously on the output together with a valid flag. The head is removed with a dequeue strobe. Full is reported so that upstream logic can generate back-pressure.

## Interface
Parameters, positional in this order:
- DATA_WIDTH, default 32: width of one entry (one flit).
- DEPTH, default 4: number of entries; any integer ≥ 2, not restricted to powers of two.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-low reset; one clock and reset is synchronous and active-low.
- data_in, input, DATA_WIDTH: entry to enqueue.
- enq, input, 1: enqueue strobe; accepted only when full is 0.
- full, output, 1: 1 when the FIFO holds DEPTH entries.
- data_out, output, DATA_WIDTH: head entry, fall-through; 0 when valid_out is 0.
- valid_out, output, 1: 1 when the FIFO holds at least one entry.
- deq, input, 1: dequeue strobe; removes the head when valid_out is 1.

## Operation
- Storage is a DEPTH-entry register array with a write pointer, a read pointer and an occupancy count.
  - Both pointers wrap from DEPTH-1 to 0.
  - The count is clog2(DEPTH+1) bits wide.
- Write: on a rising edge with reset=1, enq=1 and full=0:
  - data_in is stored at the write pointer.
  - The write pointer advances.
- Read: on a rising edge with reset=1, deq=1 and valid_out=1:
  - The read pointer advances.
  - The removed entry is not cleared.
- Count update:
  - +1 on an accepted write only.
  - −1 on an accepted read only.
  - Unchanged when both or neither are accepted.
- Ignored requests (no state change, no error flag):
  - enq while full=1: data is dropped, even if deq=1 in the same cycle.
  - deq while valid_out=0: request ignored, even if enq=1 in the same cycle; the written entry remains.
- Outputs are combinational from registered state only; there is no combinational path from enq, deq or data_in:
  - full = (count == DEPTH).
  - valid_out = (count != 0).
  - data_out = mem[read pointer] when valid_out=1, else 0.
- Reset (reset=0 at a rising edge):
  - count, pointers and all storage entries are cleared to 0.
  - Pending enq/deq in that cycle are ignored.
  - Outputs after reset: full=0, valid_out=0, data_out=0.
  - Reset asserted mid-operation discards all contents.

## Timing
- Write-to-output latency is one edge: an entry enqueued into an empty FIFO at edge N appears on data_out with valid_out=1 immediately after edge N.
- Dequeue takes effect at the edge:
  - After edge N with deq=1, data_out shows the next entry, or 0 with valid_out=0 if the FIFO became empty.
- full rises right after the edge that accepts the DEPTH-th entry. It falls right after the first accepted dequeue.
- Throughput:
  - One write and one read per cycle.
  - Simultaneous enq and deq with 0 < count < DEPTH sustains full rate with count unchanged.
- The consumer may sample data_out in the same cycle it asserts deq.

## Test plan
- Reset then idle: assert reset=0 for 2 cycles → full=0, valid_out=0, data_out=0; outputs stay stable while idle.
- Fill to full (DEPTH=4): enqueue 0x11, 0x22, 0x33, 0x44 on consecutive cycles → valid_out=1 after the first edge with data_out=0x11; full=1 after the 4th edge.
  - A 5th enq of 0x55 is dropped.
  - Draining yields 0x11, 0x22, 0x33, 0x44, then valid_out=0.
- Overflow and underflow with simultaneous strobes:
  - Full FIFO, enq=1 and deq=1 in the same cycle → head removed, new data dropped, count=3, full=0.
  - Empty FIFO, enq=1 and deq=1 → entry stored, valid_out=1, count=1.
- Streaming and wrap-around: 20 consecutive cycles with enq=deq=1 after pre-loading one entry → in-order data, count constant at 1, pointers wrap several times with no loss.
- Non-power-of-two depth: DEPTH=3, write 3 entries, read 2, write 2 → full=1; read order is correct across the wrap at index 2→0.
- Mid-operation reset: with 2 entries held, assert reset=0 for one edge while enq=1 → valid_out=0, full=0, data_out=0; the next enqueued value is the first one read.

Source files
------------

// File: rtl/basic_sync_fifo.sv
// First-word-fall-through single-clock FIFO used as the NoC link flit buffer.
// Head entry is presented combinationally from registered state; DEPTH need not be a power of two.
module basic_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  enq,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  deq
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;

    logic wr_accept;
    logic rd_accept;

    assign full      = (count_q == FULL_CNT);
    assign valid_out = (count_q != '0);
    assign data_out  = valid_out ? mem_q[rd_ptr_q] : '0;

    // Acceptance depends only on registered flags, so a dropped enq never
    // becomes legal just because a deq frees a slot in the same cycle.
    assign wr_accept = enq && !full;
    assign rd_accept = deq && valid_out;

    // NOTE: every signal gets its default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_accept) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        if (rd_accept) begin
            rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every flop samples the
    // pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: storage is cleared on reset as well, so stale flits can
            // never reappear after a mid-operation reset.
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_basic_sync_fifo.sv
// Self-checking bench for basic_sync_fifo: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_basic_sync_fifo;

    localparam int DW = 8;

    logic          clock;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          enq;
    logic          deq;

    logic          full4, valid4;
    logic [DW-1:0] dout4;
    logic          full3, valid3;
    logic [DW-1:0] dout3;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] q4[$];
    logic [DW-1:0] q3[$];

    basic_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(4)) dut4 (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .enq      (enq),
        .full     (full4),
        .data_out (dout4),
        .valid_out(valid4),
        .deq      (deq)
    );

    basic_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(3)) dut3 (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .enq      (enq),
        .full     (full3),
        .data_out (dout3),
        .valid_out(valid3),
        .deq      (deq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          rst_n;
        logic          enq;
        logic          deq;
        logic [DW-1:0] din;
        logic          exp_full;
        logic          exp_valid;
        logic [DW-1:0] exp_dout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_dut(input string tag, input logic f, input logic v, input logic [DW-1:0] d,
                             input logic ef, input logic ev, input logic [DW-1:0] ed);
        check({tag, ".full"},      32'(f), 32'(ef));
        check({tag, ".valid_out"}, 32'(v), 32'(ev));
        check({tag, ".data_out"},  32'(d), 32'(ed));
    endtask

    // Reference behaviour: a bounded queue; requests judged on pre-edge occupancy.
    task automatic model_update(input logic r, input logic e, input logic d, input logic [DW-1:0] x);
        logic w4, r4, w3, r3;
        if (!r) begin
            q4.delete();
            q3.delete();
        end else begin
            w4 = e && (q4.size() < 4);
            r4 = d && (q4.size() > 0);
            w3 = e && (q3.size() < 3);
            r3 = d && (q3.size() > 0);
            if (r4) void'(q4.pop_front());
            if (w4) q4.push_back(x);
            if (r3) void'(q3.pop_front());
            if (w3) q3.push_back(x);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic d, input logic [DW-1:0] x);
        reset   = r;
        enq     = e;
        deq     = d;
        data_in = x;
        @(posedge clock);
        model_update(r, e, d, x);
        #1;
    endtask

    task automatic check_model(input string tag);
        check_dut({tag, "/d4"}, full4, valid4, dout4,
                  q4.size() == 4, q4.size() != 0, (q4.size() != 0) ? q4[0] : '0);
        check_dut({tag, "/d3"}, full3, valid3, dout3,
                  q3.size() == 3, q3.size() != 0, (q3.size() != 0) ? q3[0] : '0);
    endtask

    vec_t vecs[$];

    initial begin
        reset   = 1'b0;
        enq     = 1'b0;
        deq     = 1'b0;
        data_in = '0;

        // rst_n enq deq din | full valid dout  (expected after the edge, DEPTH=4)
        vecs = '{
            '{0, 0, 0, 8'h00, 0, 0, 8'h00},
            '{0, 1, 1, 8'hAA, 0, 0, 8'h00},
            '{1, 0, 0, 8'h00, 0, 0, 8'h00},
            '{1, 0, 0, 8'h00, 0, 0, 8'h00},
            '{1, 1, 0, 8'h11, 0, 1, 8'h11},
            '{1, 1, 0, 8'h22, 0, 1, 8'h11},
            '{1, 1, 0, 8'h33, 0, 1, 8'h11},
            '{1, 1, 0, 8'h44, 1, 1, 8'h11},
            '{1, 1, 0, 8'h55, 1, 1, 8'h11},
            '{1, 0, 1, 8'h00, 0, 1, 8'h22},
            '{1, 0, 1, 8'h00, 0, 1, 8'h33},
            '{1, 0, 1, 8'h00, 0, 1, 8'h44},
            '{1, 0, 1, 8'h00, 0, 0, 8'h00},
            '{1, 0, 1, 8'h00, 0, 0, 8'h00},
            '{1, 1, 1, 8'h66, 0, 1, 8'h66},
            '{1, 1, 0, 8'h77, 0, 1, 8'h66},
            '{1, 1, 0, 8'h88, 0, 1, 8'h66},
            '{1, 1, 0, 8'h99, 1, 1, 8'h66},
            '{1, 1, 1, 8'hBB, 0, 1, 8'h77},
            '{1, 1, 0, 8'hCC, 1, 1, 8'h77},
            '{1, 0, 1, 8'h00, 0, 1, 8'h88},
            '{1, 0, 1, 8'h00, 0, 1, 8'h99},
            '{1, 0, 1, 8'h00, 0, 1, 8'hCC},
            '{1, 0, 1, 8'h00, 0, 0, 8'h00},
            '{1, 1, 0, 8'hD1, 0, 1, 8'hD1},
            '{1, 1, 0, 8'hD2, 0, 1, 8'hD1},
            '{0, 1, 0, 8'hD3, 0, 0, 8'h00},
            '{1, 1, 0, 8'hE1, 0, 1, 8'hE1},
            '{1, 0, 1, 8'h00, 0, 0, 8'h00}
        };

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].enq, vecs[i].deq, vecs[i].din);
            check_dut($sformatf("vec%0d", i), full4, valid4, dout4,
                      vecs[i].exp_full, vecs[i].exp_valid, vecs[i].exp_dout);
        end

        // Streaming: one preloaded entry, then 20 cycles of enq=deq=1.
        step(1'b1, 1'b1, 1'b0, 8'h80);
        for (int i = 0; i < 20; i++) begin
            logic [DW-1:0] prev;
            prev = 8'h80 + DW'(i);
            check($sformatf("stream%0d.pre_dout", i), 32'(dout4), 32'(prev));
            step(1'b1, 1'b1, 1'b1, prev + 8'h01);
            check_dut($sformatf("stream%0d", i), full4, valid4, dout4, 1'b0, 1'b1, prev + 8'h01);
        end
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check_dut("stream_drain", full4, valid4, dout4, 1'b0, 1'b0, 8'h00);

        // DEPTH=3: write 3, read 2, write 2 (wraps index 2 -> 0), then drain.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'hA1);
        step(1'b1, 1'b1, 1'b0, 8'hA2);
        step(1'b1, 1'b1, 1'b0, 8'hA3);
        check_dut("d3_fill", full3, valid3, dout3, 1'b1, 1'b1, 8'hA1);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check_dut("d3_read2", full3, valid3, dout3, 1'b0, 1'b1, 8'hA3);
        step(1'b1, 1'b1, 1'b0, 8'hB1);
        step(1'b1, 1'b1, 1'b0, 8'hB2);
        check_dut("d3_refill", full3, valid3, dout3, 1'b1, 1'b1, 8'hA3);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check_dut("d3_rd_b1", full3, valid3, dout3, 1'b0, 1'b1, 8'hB1);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check_dut("d3_rd_b2", full3, valid3, dout3, 1'b0, 1'b1, 8'hB2);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check_dut("d3_empty", full3, valid3, dout3, 1'b0, 1'b0, 8'h00);

        // Randomized traffic, both depths, against the queue model.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_model("rnd_reset");
        for (int i = 0; i < 400; i++) begin
            logic r, e, d;
            r = ($urandom_range(0, 99) >= 2);
            e = ($urandom_range(0, 99) < 60);
            d = ($urandom_range(0, 99) < 50);
            step(r, e, d, DW'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
